// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: mode states, read owner tags,
// request-vector indices and the starvation counter width helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_INSTR  = 2'd1,
      TAG_DATA   = 2'd2,
      TAG_LOADER = 2'd3
   } tag_t;

   localparam int REQ_I = 0;
   localparam int REQ_D = 1;
   localparam int NREQ  = 2;

   // A zero limit still needs a one-bit counter so the port widths stay legal.
   function automatic int starve_w(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_port_prio_sel.sv
// Fixed-priority core selector: data ahead of fetch unless fetch is promoted.
// Purely combinational, one-hot or empty grant.
module mem_port_prio_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            promote,
   output logic [NREQ-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (promote && req[REQ_I]) begin
         gnt[REQ_I] = 1'b1;
      end else if (req[REQ_D]) begin
         gnt[REQ_D] = 1'b1;
      end else if (req[REQ_I]) begin
         gnt[REQ_I] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between fetch, data and loader ports: same-cycle grants,
// read data returned one cycle later to the tagged owner, loader mode holds the core.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 12,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          ld_mode_req,
   output logic          ld_own,
   output logic          core_hold,

   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,

   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,

   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   output logic          i_stall,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   localparam int            SW    = starve_w(STARVE_LIMIT);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   state_t          state;
   tag_t            tag;
   tag_t            tag_nxt;
   logic [SW-1:0]   starve_cnt;
   logic            promote;
   logic [NREQ-1:0] core_req;
   logic [NREQ-1:0] core_gnt;

   assign promote = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

   // Core requests only compete in RUN; reset masks every grant.
   always_comb begin
      core_req = '0;
      if (!rst && state == ST_RUN) begin
         core_req[REQ_I] = i_req;
         core_req[REQ_D] = d_req;
      end
   end

   mem_port_prio_sel u_prio_sel (
      .req     (core_req),
      .promote (promote),
      .gnt     (core_gnt)
   );

   assign i_gnt   = core_gnt[REQ_I];
   assign d_gnt   = core_gnt[REQ_D];
   assign ld_gnt  = !rst && (state == ST_LOAD) && ld_req;
   assign i_stall = i_req && !i_gnt;

   // Idle cycles park the address on the fetch port so a late fetch sees a stable bus.
   always_comb begin
      mem_addr  = i_addr;
      mem_wdata = '0;
      mem_we    = 1'b0;
      tag_nxt   = TAG_NONE;
      if (ld_gnt) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
         mem_we    = ld_we;
         tag_nxt   = ld_we ? TAG_NONE : TAG_LOADER;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_we    = d_we;
         tag_nxt   = d_we ? TAG_NONE : TAG_DATA;
      end else if (i_gnt) begin
         mem_addr  = i_addr;
         tag_nxt   = TAG_INSTR;
      end
   end

   assign i_rvalid  = (tag == TAG_INSTR);
   assign d_rvalid  = (tag == TAG_DATA);
   assign ld_rvalid = (tag == TAG_LOADER);
   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign ld_rdata  = mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         ld_own    <= 1'b0;
         core_hold <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (ld_mode_req) begin
                  state     <= ST_DRAIN;
                  core_hold <= 1'b1;
               end
            end
            // A read granted on the entry cycle returns during the first DRAIN cycle;
            // only once that tag has cleared is the memory handed over.
            ST_DRAIN: begin
               if (!ld_mode_req) begin
                  state     <= ST_RUN;
                  core_hold <= 1'b0;
               end else if (tag == TAG_NONE) begin
                  state  <= ST_LOAD;
                  ld_own <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (!ld_mode_req) begin
                  state     <= ST_RUN;
                  ld_own    <= 1'b0;
                  core_hold <= 1'b0;
               end
            end
            default: begin
               state     <= ST_RUN;
               ld_own    <= 1'b0;
               core_hold <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag <= TAG_NONE;
      end else begin
         tag <= tag_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || state != ST_RUN || !i_req || i_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed sequences, an arbitration vector table, then
// randomized traffic checked against a cycle-level reference model and a model memory.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_mode_req, ld_own, core_hold;
   logic          ld_req, ld_we, ld_gnt, ld_rvalid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata, ld_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          i_req, i_gnt, i_rvalid, i_stall;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_we;

   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_dat = '0;
   logic [DW-1:0] mem_arr [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .ld_mode_req(ld_mode_req), .ld_own(ld_own), .core_hold(core_hold),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_stall(i_stall),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // Synchronous-read memory with a backdoor write port for preloading.
   always @(posedge clk) begin
      if (bd_we) mem_arr[bd_addr] <= bd_dat;
      else if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
      d_req = 0;  d_we = 0;  d_addr = '0;  d_wdata = '0;
      i_req = 0;  i_addr = '0;
   endtask

   task automatic do_reset();
      rst = 1; ld_mode_req = 0; idle_inputs();
      tick(); tick();
      rst = 0;
   endtask

   task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
      bd_we = 1; bd_addr = a; bd_dat = v;
      tick();
      bd_we = 0;
   endtask

   function automatic logic [AW-1:0] raddr();
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = '1;
      else a = AW'($urandom_range(0, 15));
      return a;
   endfunction

   typedef struct {
      logic d_req;
      logic i_req;
      logic e_d;
      logic e_i;
      int   e_cnt;
   } vec_t;

   vec_t tbl [14];

   // Reference model state.
   state_t        m_mode;
   tag_t          m_pend, n_pend;
   logic [DW-1:0] m_pend_dat, n_pend_dat;
   int            m_starve;
   logic [DW-1:0] m_mem [0:(1<<AW)-1];

   initial begin
      logic e_i, e_d, e_l, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;

      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 3};

      // Reset, then idle.
      #1;
      do_reset();
      #3;
      chk("idle_i_gnt", i_gnt, 0);   chk("idle_d_gnt", d_gnt, 0);   chk("idle_ld_gnt", ld_gnt, 0);
      chk("idle_i_rv", i_rvalid, 0); chk("idle_d_rv", d_rvalid, 0); chk("idle_ld_rv", ld_rvalid, 0);
      chk("idle_ld_own", ld_own, 0); chk("idle_hold", core_hold, 0); chk("idle_mem_we", mem_we, 0);
      chk("idle_cnt", 32'(dut.starve_cnt), 0);
      tick();

      bd_write(12'h010, 32'h12345678);
      bd_write(12'h020, 32'h0);
      bd_write(12'h030, 32'hCAFEF00D);
      bd_write(12'hFFF, 32'hA5A5A5A5);

      // Single fetch read.
      i_req = 1; i_addr = 12'h010;
      #3;
      chk("rd_i_gnt", i_gnt, 1); chk("rd_mem_addr", mem_addr, 12'h010); chk("rd_mem_we", mem_we, 0);
      tick();
      i_req = 0;
      #3;
      chk("rd_i_rv", i_rvalid, 1); chk("rd_i_rdata", i_rdata, 32'h12345678);
      chk("rd_d_rv", d_rvalid, 0); chk("rd_ld_rv", ld_rvalid, 0);
      tick();

      // Data write then fetch read of the same word.
      d_req = 1; d_we = 1; d_addr = 12'h020; d_wdata = 32'hDEADBEEF;
      #3;
      chk("wr_d_gnt", d_gnt, 1); chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 12'h020); chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      d_req = 0; d_we = 0; i_req = 1; i_addr = 12'h020;
      #3;
      chk("wr_i_gnt", i_gnt, 1); chk("wr_mem_we2", mem_we, 0); chk("wr_no_d_rv", d_rvalid, 0);
      tick();
      i_req = 0;
      #3;
      chk("wr_i_rv", i_rvalid, 1); chk("wr_i_rdata", i_rdata, 32'hDEADBEEF);
      tick();

      // Arbitration / starvation table.
      for (int r = 0; r < 14; r++) begin
         d_req = tbl[r].d_req; d_we = 0; d_addr = 12'h030;
         i_req = tbl[r].i_req; i_addr = 12'h010;
         #3;
         chk($sformatf("tbl%0d_d_gnt", r), d_gnt, tbl[r].e_d);
         chk($sformatf("tbl%0d_i_gnt", r), i_gnt, tbl[r].e_i);
         chk($sformatf("tbl%0d_stall", r), i_stall, tbl[r].i_req & ~tbl[r].e_i);
         chk($sformatf("tbl%0d_cnt", r), 32'(dut.starve_cnt), tbl[r].e_cnt);
         tick();
      end
      idle_inputs();
      tick();

      // Data read in the same cycle the loader asks for the memory.
      d_req = 1; d_addr = 12'h030; ld_mode_req = 1;
      #3;
      chk("lm_d_gnt", d_gnt, 1); chk("lm_hold0", core_hold, 0);
      tick();
      d_req = 1; i_req = 1; i_addr = 12'h010;
      #3;
      chk("lm_d_rv", d_rvalid, 1); chk("lm_d_rdata", d_rdata, 32'hCAFEF00D);
      chk("lm_hold1", core_hold, 1); chk("lm_own_dr1", ld_own, 0);
      chk("lm_dr_d_gnt", d_gnt, 0); chk("lm_dr_i_gnt", i_gnt, 0); chk("lm_dr_stall", i_stall, 1);
      tick();
      #3;
      chk("lm_own_dr2", ld_own, 0); chk("lm_dr2_d_gnt", d_gnt, 0); chk("lm_dr2_d_rv", d_rvalid, 0);
      tick();
      ld_req = 1; ld_we = 1; ld_addr = 12'hFFF; ld_wdata = 32'h0;
      #3;
      chk("lm_own", ld_own, 1); chk("lm_ld_gnt_w", ld_gnt, 1); chk("lm_mem_we", mem_we, 1);
      chk("lm_ld_d_gnt", d_gnt, 0); chk("lm_ld_i_gnt", i_gnt, 0); chk("lm_mem_addr", mem_addr, 12'hFFF);
      tick();
      ld_we = 0;
      #3;
      chk("lm_ld_gnt_r", ld_gnt, 1); chk("lm_ld_rv_w", ld_rvalid, 0);
      tick();
      ld_req = 0; ld_mode_req = 0;
      #3;
      chk("lm_ld_rv", ld_rvalid, 1); chk("lm_ld_rdata", ld_rdata, 32'h0);
      chk("lm_hold_ld", core_hold, 1); chk("lm_ld_i_rv", i_rvalid, 0);
      tick();
      #3;
      chk("lm_hold_off", core_hold, 0); chk("lm_own_off", ld_own, 0); chk("lm_run_d_gnt", d_gnt, 1);
      tick();
      idle_inputs();
      tick();

      // Reset pulse with a read in flight and the counter part-way up.
      d_req = 1; d_addr = 12'h030; i_req = 1; i_addr = 12'h010;
      tick();
      ld_mode_req = 1;
      tick();
      ld_mode_req = 0; rst = 1; d_we = 1; d_wdata = 32'h11111111;
      #3;
      chk("rs_hold_pre", core_hold, 1); chk("rs_cnt_pre", 32'(dut.starve_cnt), 2);
      chk("rs_d_gnt", d_gnt, 0); chk("rs_i_gnt", i_gnt, 0); chk("rs_mem_we", mem_we, 0);
      tick();
      rst = 0; idle_inputs();
      #3;
      chk("rs_d_rv", d_rvalid, 0); chk("rs_i_rv", i_rvalid, 0);
      chk("rs_hold", core_hold, 0); chk("rs_cnt", 32'(dut.starve_cnt), 0);
      tick();
      #3;
      chk("rs_d_rv2", d_rvalid, 0);
      tick();

      // Randomized traffic against the reference model.
      do_reset();
      for (int a = 0; a < 16; a++) begin
         m_mem[a] = $urandom;
         bd_write(AW'(a), m_mem[a]);
      end
      m_mem[(1<<AW)-1] = $urandom;
      bd_write('1, m_mem[(1<<AW)-1]);
      m_mode = ST_RUN; m_pend = TAG_NONE; m_pend_dat = '0; m_starve = 0;

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 24) == 0) ld_mode_req = !ld_mode_req;
         i_req = 1'($urandom_range(0, 1)); i_addr = raddr();
         d_req = 1'($urandom_range(0, 1)); d_we = ($urandom_range(0, 3) == 0);
         d_addr = raddr(); d_wdata = $urandom;
         ld_req = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
         ld_addr = raddr(); ld_wdata = $urandom;
         #3;
         e_i = 0; e_d = 0; e_l = 0;
         if (m_mode == ST_RUN) begin
            if (i_req && d_req) begin
               if (LIM > 0 && m_starve == LIM) e_i = 1;
               else e_d = 1;
            end else begin
               e_i = i_req; e_d = d_req;
            end
         end else if (m_mode == ST_LOAD) begin
            e_l = ld_req;
         end
         e_we = (e_l && ld_we) || (e_d && d_we);
         e_addr = e_l ? ld_addr : (e_d ? d_addr : i_addr);
         e_wdata = e_l ? ld_wdata : (e_d ? d_wdata : '0);

         chk("rnd_i_gnt", i_gnt, e_i); chk("rnd_d_gnt", d_gnt, e_d); chk("rnd_ld_gnt", ld_gnt, e_l);
         chk("rnd_stall", i_stall, i_req && !e_i);
         chk("rnd_mem_we", mem_we, e_we); chk("rnd_mem_addr", mem_addr, e_addr);
         if (e_we || !(e_i || e_d || e_l)) chk("rnd_mem_wdata", mem_wdata, e_wdata);
         chk("rnd_i_rv", i_rvalid, m_pend == TAG_INSTR);
         chk("rnd_d_rv", d_rvalid, m_pend == TAG_DATA);
         chk("rnd_ld_rv", ld_rvalid, m_pend == TAG_LOADER);
         if (m_pend == TAG_INSTR) chk("rnd_i_rdata", i_rdata, m_pend_dat);
         if (m_pend == TAG_DATA) chk("rnd_d_rdata", d_rdata, m_pend_dat);
         if (m_pend == TAG_LOADER) chk("rnd_ld_rdata", ld_rdata, m_pend_dat);
         chk("rnd_ld_own", ld_own, m_mode == ST_LOAD);
         chk("rnd_hold", core_hold, m_mode != ST_RUN);

         n_pend = TAG_NONE; n_pend_dat = '0;
         if (e_l && !ld_we) begin n_pend = TAG_LOADER; n_pend_dat = m_mem[ld_addr]; end
         if (e_d && !d_we) begin n_pend = TAG_DATA; n_pend_dat = m_mem[d_addr]; end
         if (e_i) begin n_pend = TAG_INSTR; n_pend_dat = m_mem[i_addr]; end
         if (e_l && ld_we) m_mem[ld_addr] = ld_wdata;
         if (e_d && d_we) m_mem[d_addr] = d_wdata;

         if (m_mode == ST_RUN && i_req && !e_i) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
         else m_starve = 0;

         case (m_mode)
            ST_RUN:   if (ld_mode_req) m_mode = ST_DRAIN;
            ST_DRAIN: if (!ld_mode_req) m_mode = ST_RUN;
                      else if (m_pend == TAG_NONE) m_mode = ST_LOAD;
            default:  if (!ld_mode_req) m_mode = ST_RUN;
         endcase
         m_pend = n_pend; m_pend_dat = n_pend_dat;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, synchronous-read word memory between the core's instruction fetch port, the core's data (MM-stage) port, and an external program loader. It replaces the separate imem/dmem instances with one unified memory. It arbitrates per cycle with a starvation guard for fetch, and routes read data back to the winning requester one cycle later. A small mode FSM hands the memory exclusively to the loader and holds the core while it does so.

## Interface
Parameters:
- AW, 12, word-address width (memory depth 2**AW words)
- DW, 32, data width
- STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is promoted to top priority; 0 disables promotion

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ld_mode_req  in  1  loader requests exclusive ownership (level)
- ld_own  out  1  loader owns memory
- core_hold  out  1  core must not advance (state != RUN)
- ld_req, ld_we  in  1  loader access request / write enable
- ld_addr  in  AW  loader word address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader access accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DW  loader read data
- d_req, d_we  in  1  data port request / write enable
- d_addr  in  AW;  d_wdata  in  DW
- d_gnt  out  1;  d_rvalid  out  1;  d_rdata  out  DW
- i_req  in  1;  i_addr  in  AW
- i_gnt  out  1;  i_rvalid  out  1;  i_rdata  out  DW
- i_stall  out  1  i_req && !i_gnt
- mem_addr  out  AW;  mem_wdata  out  DW;  mem_we  out  1
- mem_rdata  in  DW  memory output, valid the cycle after the address is presented

## Operation
- Mode FSM, states RUN, DRAIN, LOAD; reset state RUN.
  - RUN -> DRAIN when ld_mode_req=1.
  - DRAIN: no grants. Moves to LOAD when no read is outstanding. At most 1 cycle is spent in DRAIN beyond the entry cycle.
  - LOAD -> RUN when ld_mode_req=0.
  - DRAIN -> RUN directly if ld_mode_req drops while in DRAIN.
- ld_own = (state==LOAD).
- core_hold = (state!=RUN).
- Grants are combinational, issued in the same cycle as the request. At most one grant per cycle.
- RUN priority: data > fetch. When starve_cnt == STARVE_LIMIT (nonzero), fetch > data.
- The loader's ld_req is ignored outside LOAD. In LOAD, only the loader is granted; d_req and i_req get no grant.
- The winning requester's addr, wdata and we drive mem_*. mem_we = granted && we.
- With no grant: mem_we=0, mem_addr=i_addr, mem_wdata=0.
- A granted read (we=0) sets a 2-bit owner tag. The following cycle, the matching *_rvalid=1 for exactly one cycle.
- All *_rdata outputs = mem_rdata combinationally; only the rvalid qualifies them.
- Granted writes produce no rvalid.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - increments, saturating at STARVE_LIMIT, each RUN cycle with i_req && !i_gnt;
  - clears on i_gnt, on !i_req, and outside RUN.
- Reset values: state RUN, owner tag none, starve_cnt 0. Therefore ld_own=0, core_hold=0 and all *_rvalid=0.
- While rst=1, all grants and mem_we are forced 0.
- Reset mid-operation drops any outstanding read; no rvalid is issued after the reset cycle.

## Timing
- Request-to-grant latency is 0 cycles. Grant-to-rvalid latency is exactly 1 cycle.
- Throughput is one access per cycle, back-to-back, with any mix of requesters.
- ld_own rises no earlier than the cycle after the last read's rvalid.
- core_hold rises the cycle after ld_mode_req is sampled high in RUN. It falls the cycle after ld_mode_req is sampled low in LOAD.
- Simultaneous d_req and i_req with starve_cnt at limit: fetch wins, the counter clears next cycle, and data waits one cycle.
- Address is held by the requester until gnt is seen; the arbiter does not latch requests.

## Structure
- Shared package/header: the state encoding (RUN=0, DRAIN=1, LOAD=2) and the owner-tag encoding (NONE=0, INSTR=1, DATA=2, LOADER=3), so the bench and a future debug block decode them identically.
- One natural sub-module: mem_port_prio_sel, a pure priority selector taking the req vector and promote flag and returning a one-hot grant. Everything else stays in the top.

## Test plan
- Reset, then idle: all gnt=0, all rvalid=0, ld_own=0, core_hold=0, mem_we=0.
- i_req only, addr 0x010, mem word 0x12345678 -> i_gnt same cycle; next cycle i_rvalid=1 and i_rdata=0x12345678; d_rvalid stays 0.
- d_req and i_req held 4 cycles with STARVE_LIMIT=3 -> d_gnt in cycles 0–2, i_gnt in cycle 3; starve_cnt returns to 0.
- d_req write 0xDEADBEEF to 0x020, then i_req read 0x020 -> mem_we=1 for one cycle; i_rdata=0xDEADBEEF one cycle after i_gnt.
- d_req read granted, then ld_mode_req=1 in the same cycle -> d_rvalid next cycle; DRAIN; then LOAD with ld_own=1. d_req/i_req get no grant. Loader writes 0x0 to 0xFFF and reads it back with ld_rvalid.
- Mid-read rst pulse -> no rvalid after reset; state RUN; starve_cnt 0.
